// File: rtl/cache_control_param.sv
// Cache controller FSM for the direct-mapped data cache.
// Turns CPU strobe requests into cache-array writes, memory strobes and CPU
// ready pulses. A wait-state counter times each memory access. The block
// supports write-through or write-back (with dirty-line eviction) and keeps
// saturating hit/miss statistics.
module cache_control_param #(
    parameter int WAIT_CYCLES = 4,
    parameter int CTR_W       = 8,
    parameter int WRITE_BACK  = 0,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Strobe,
    input  logic              DRW,
    input  logic              M,
    input  logic              V,
    input  logic              Dirty,
    output logic              DReady,
    output logic              W,
    output logic              DirtySet,
    output logic              MStrobe,
    output logic              MRW,
    output logic              RSel,
    output logic              WSel,
    output logic              Busy,
    output logic [STAT_W-1:0] HitCount,
    output logic [STAT_W-1:0] MissCount
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_READ       = 4'd1;
    localparam logic [3:0] S_WRITE      = 4'd2;
    localparam logic [3:0] S_EVICT      = 4'd3;
    localparam logic [3:0] S_EVICT_MEM  = 4'd4;
    localparam logic [3:0] S_READ_MISS  = 4'd5;
    localparam logic [3:0] S_READ_MEM   = 4'd6;
    localparam logic [3:0] S_READ_DATA  = 4'd7;
    localparam logic [3:0] S_WRITE_MEM  = 4'd8;
    localparam logic [3:0] S_WRITE_DATA = 4'd9;
    localparam logic [3:0] S_WRITE_ALLC = 4'd10;

    // The counter is loaded with one less than the wait count so that a
    // *_MEM state spends exactly WAIT_CYCLES cycles before it sees zero.
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(WAIT_CYCLES - 1);
    localparam logic             WB       = (WRITE_BACK != 0);

    logic [3:0]        state_q, state_d;
    logic [CTR_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;
    logic              hit_s, ctr_done_s, dirty_evict_s;
    logic              hit_inc_s, miss_inc_s;

    assign hit_s         = M & V;
    assign ctr_done_s    = (cnt_q == {CTR_W{1'b0}});
    // Only a valid dirty line needs writing back, and only in write-back mode.
    assign dirty_evict_s = WB & V & Dirty;

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;

    // Next-state, counter and output decode (outputs are Mealy on Hit).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hit_inc_s  = 1'b0;
        miss_inc_s = 1'b0;
        DReady     = 1'b0;
        W          = 1'b0;
        DirtySet   = 1'b0;
        MStrobe    = 1'b0;
        MRW        = 1'b0;
        RSel       = 1'b0;
        WSel       = 1'b0;
        Busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (Strobe) begin
                    state_d = DRW ? S_WRITE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (hit_s) begin
                    hit_inc_s = 1'b1;
                    DReady    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    miss_inc_s = 1'b1;
                    state_d    = dirty_evict_s ? S_EVICT : S_READ_MISS;
                end
            end
            S_EVICT: begin
                MStrobe = 1'b1;
                MRW     = 1'b1;
                cnt_d   = CTR_LOAD;
                state_d = S_EVICT_MEM;
            end
            S_EVICT_MEM: begin
                if (ctr_done_s) begin
                    // A write miss resumes with allocation, a read miss with the refill.
                    state_d = (WB && DRW) ? S_WRITE_ALLC : S_READ_MISS;
                end else begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            S_READ_MISS: begin
                MStrobe = 1'b1;
                cnt_d   = CTR_LOAD;
                state_d = S_READ_MEM;
            end
            S_READ_MEM: begin
                if (ctr_done_s) begin
                    state_d = S_READ_DATA;
                end else begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            S_READ_DATA: begin
                W       = 1'b1;
                WSel    = 1'b1;
                RSel    = 1'b1;
                DReady  = 1'b1;
                state_d = S_IDLE;
            end
            S_WRITE: begin
                if (WB) begin
                    if (hit_s) begin
                        hit_inc_s = 1'b1;
                        W         = 1'b1;
                        DirtySet  = 1'b1;
                        DReady    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        miss_inc_s = 1'b1;
                        state_d    = dirty_evict_s ? S_EVICT : S_WRITE_ALLC;
                    end
                end else begin
                    // Write-through: always go to memory; update the array only on a hit.
                    hit_inc_s  = hit_s;
                    miss_inc_s = ~hit_s;
                    MStrobe    = 1'b1;
                    MRW        = 1'b1;
                    W          = hit_s;
                    cnt_d      = CTR_LOAD;
                    state_d    = S_WRITE_MEM;
                end
            end
            S_WRITE_MEM: begin
                if (ctr_done_s) begin
                    state_d = S_WRITE_DATA;
                end else begin
                    cnt_d = cnt_q - CTR_W'(1);
                end
            end
            S_WRITE_DATA: begin
                DReady  = 1'b1;
                state_d = S_IDLE;
            end
            S_WRITE_ALLC: begin
                if (WB) begin
                    W        = 1'b1;
                    DirtySet = 1'b1;
                    DReady   = 1'b1;
                end else begin
                    DReady = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, wait counter and saturating statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CTR_W{1'b0}};
            hit_cnt_q  <= {STAT_W{1'b0}};
            miss_cnt_q <= {STAT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hit_inc_s && (hit_cnt_q != {STAT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + STAT_W'(1);
            end else begin
                hit_cnt_q <= hit_cnt_q;
            end
            if (miss_inc_s && (miss_cnt_q != {STAT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + STAT_W'(1);
            end else begin
                miss_cnt_q <= miss_cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_control_param.sv
// Bench for cache_control_param: three configurations, a transaction-level
// model that expands each request into its per-cycle expected outputs, and
// one compare process that checks every DUT on every cycle.
module tb_cache_control_param;

    localparam logic [7:0] DR = 8'h80, WR = 8'h40, DS = 8'h20, MS = 8'h10;
    localparam logic [7:0] MW = 8'h08, RS = 8'h04, WS = 8'h02, BZ = 8'h01;

    typedef struct {
        logic [7:0] o;
        int         h;
        int         m;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] reset, strobe, drw, m, v, dirty;
    logic [2:0] dready, w, ds, ms, mrw, rsel, wsel, busy;
    logic [15:0] hc0, mc0, hc1, mc1;
    logic [1:0]  hc2, mc2;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    exp_t q0[$], q1[$], q2[$];
    int   cfg_wb[3]  = '{0, 1, 0};
    int   cfg_wc[3]  = '{4, 2, 1};
    int   cfg_max[3] = '{65535, 65535, 3};
    int   mh[3] = '{0, 0, 0};
    int   mm[3] = '{0, 0, 0};
    int   start[3] = '{0, 0, 0};
    int   lat[3] = '{-1, -1, -1};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cache_control_param #(.WAIT_CYCLES(4), .CTR_W(8), .WRITE_BACK(0), .STAT_W(16)) dut0 (
        .clk(clk), .reset(reset[0]), .Strobe(strobe[0]), .DRW(drw[0]), .M(m[0]), .V(v[0]),
        .Dirty(dirty[0]), .DReady(dready[0]), .W(w[0]), .DirtySet(ds[0]), .MStrobe(ms[0]),
        .MRW(mrw[0]), .RSel(rsel[0]), .WSel(wsel[0]), .Busy(busy[0]),
        .HitCount(hc0), .MissCount(mc0));

    cache_control_param #(.WAIT_CYCLES(2), .CTR_W(8), .WRITE_BACK(1), .STAT_W(16)) dut1 (
        .clk(clk), .reset(reset[1]), .Strobe(strobe[1]), .DRW(drw[1]), .M(m[1]), .V(v[1]),
        .Dirty(dirty[1]), .DReady(dready[1]), .W(w[1]), .DirtySet(ds[1]), .MStrobe(ms[1]),
        .MRW(mrw[1]), .RSel(rsel[1]), .WSel(wsel[1]), .Busy(busy[1]),
        .HitCount(hc1), .MissCount(mc1));

    cache_control_param #(.WAIT_CYCLES(1), .CTR_W(8), .WRITE_BACK(0), .STAT_W(2)) dut2 (
        .clk(clk), .reset(reset[2]), .Strobe(strobe[2]), .DRW(drw[2]), .M(m[2]), .V(v[2]),
        .Dirty(dirty[2]), .DReady(dready[2]), .W(w[2]), .DirtySet(ds[2]), .MStrobe(ms[2]),
        .MRW(mrw[2]), .RSel(rsel[2]), .WSel(wsel[2]), .Busy(busy[2]),
        .HitCount(hc2), .MissCount(mc2));

    function automatic void push(int d, logic [7:0] o, int h, int mi);
        exp_t e;
        e.o = o; e.h = h; e.m = mi;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Expand one request into expected output vectors, cycle 0 = Strobe sample.
    function automatic void gen(int d, bit rw, bit mm_i, bit vv, bit dd);
        logic [7:0] seq[$];
        int  oh = mh[d];
        int  om = mm[d];
        bit  hit = mm_i & vv;
        bit  wb = (cfg_wb[d] != 0);
        int  wc = cfg_wc[d];
        if (hit) mh[d] = (oh < cfg_max[d]) ? oh + 1 : oh;
        else     mm[d] = (om < cfg_max[d]) ? om + 1 : om;
        if (!rw) begin
            if (hit) seq.push_back(DR | BZ);
            else begin
                seq.push_back(BZ);
                if (wb && vv && dd) begin
                    seq.push_back(MS | MW | BZ);
                    repeat (wc) seq.push_back(BZ);
                end
                seq.push_back(MS | BZ);
                repeat (wc) seq.push_back(BZ);
                seq.push_back(DR | WR | WS | RS | BZ);
            end
        end else if (!wb) begin
            seq.push_back(MS | MW | BZ | (hit ? WR : 8'h00));
            repeat (wc) seq.push_back(BZ);
            seq.push_back(DR | BZ);
        end else if (hit) begin
            seq.push_back(WR | DS | DR | BZ);
        end else begin
            seq.push_back(BZ);
            if (vv && dd) begin
                seq.push_back(MS | MW | BZ);
                repeat (wc) seq.push_back(BZ);
            end
            seq.push_back(WR | DS | DR | BZ);
        end
        push(d, 8'h00, oh, om);
        push(d, seq[0], oh, om);
        for (int i = 1; i < seq.size(); i++) push(d, seq[i], mh[d], mm[d]);
    endfunction

    // Per-cycle comparison of every DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                exp_t       e;
                logic [7:0] act;
                int         ah, am;
                if (qsize(d) > 0) e = pop(d);
                else begin
                    e.o = 8'h00; e.h = mh[d]; e.m = mm[d];
                end
                act = {dready[d], w[d], ds[d], ms[d], mrw[d], rsel[d], wsel[d], busy[d]};
                case (d)
                    0: begin ah = int'(hc0); am = int'(mc0); end
                    1: begin ah = int'(hc1); am = int'(mc1); end
                    default: begin ah = int'(hc2); am = int'(mc2); end
                endcase
                if (act[7] === 1'b1) lat[d] = cyc - start[d];
                checks++;
                if (act !== e.o || ah != e.h || am != e.m) begin
                    errors++;
                    $display("FAIL dut%0d cyc %0d: got out=%b hit=%0d miss=%0d, want out=%b hit=%0d miss=%0d",
                             d, cyc, act, ah, am, e.o, e.h, e.m);
                end
            end
        end
    end

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Issue one request; optionally poke Strobe while busy in cycle 'poke'.
    task automatic do_req(int d, bit rw, bit mi, bit vi, bit di, int poke, int exp_lat);
        int c;
        int n;
        @(posedge clk); #2;
        start[d] = cyc;
        lat[d] = -1;
        drw[d] = rw; m[d] = mi; v[d] = vi; dirty[d] = di;
        strobe[d] = 1'b1;
        gen(d, rw, mi, vi, di);
        @(posedge clk); #2;
        c = 1; n = 0;
        strobe[d] = 1'b0;
        while (qsize(d) > 0 && n < 200) begin
            @(posedge clk); #2;
            c++; n++;
            strobe[d] = (c == poke);
        end
        strobe[d] = 1'b0;
        if (n >= 200) begin
            errors++;
            $display("FAIL timeout dut%0d: request did not drain", d);
        end
        check_int($sformatf("latency dut%0d", d), lat[d], exp_lat);
    endtask

    // Start a read miss on dut0 and reset it during the memory wait.
    task automatic do_rst_mid(int at_cycle);
        @(posedge clk); #2;
        start[0] = cyc;
        drw[0] = 1'b0; m[0] = 1'b0; v[0] = 1'b1; dirty[0] = 1'b0;
        strobe[0] = 1'b1;
        gen(0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #2;
        strobe[0] = 1'b0;
        for (int c = 2; c <= at_cycle; c++) begin
            @(posedge clk); #2;
        end
        reset[0] = 1'b1;
        @(posedge clk); #2;
        reset[0] = 1'b0;
        q0.delete();
        mh[0] = 0; mm[0] = 0;
        check_int("rst_mid busy", int'(busy[0]), 0);
        check_int("rst_mid mstrobe", int'(ms[0]), 0);
        check_int("rst_mid miss", int'(mc0), 0);
    endtask

    initial begin
        reset = 3'b111; strobe = 3'b000; drw = 3'b000;
        m = 3'b000; v = 3'b000; dirty = 3'b000;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        reset = 3'b000;
        check_int("reset hit", int'(hc0), 0);
        check_int("reset busy", int'(busy[0]), 0);

        // write-through, 4 wait states
        do_req(0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
        check_int("wt hit count", int'(hc0), 1);
        do_req(0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 7);
        check_int("wt miss count", int'(mc0), 1);
        do_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 6);
        check_int("wt write miss count", int'(mc0), 2);
        do_req(0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 6);
        check_int("wt write hit count", int'(hc0), 2);
        do_rst_mid(4);
        do_req(0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 7);
        check_int("wt dirty ignored miss", int'(mc0), 1);

        // write-back, 2 wait states
        do_req(1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 8);
        do_req(1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1);
        do_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);
        do_req(1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 5);
        do_req(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
        do_req(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
        check_int("wb hit count", int'(hc1), 2);
        check_int("wb miss count", int'(mc1), 4);

        // 2-bit statistics saturate
        repeat (5) do_req(2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4);
        check_int("sat miss count", int'(mc2), 3);
        check_int("sat hit count", int'(hc2), 0);

        @(posedge clk); #2;
        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_control_param.md
Name: cache_control_param

Overview:
Parametrised next-generation cache controller FSM for the direct-mapped data cache. It sequences CPU Strobe requests into cache-array writes, memory strobes and CPU ready, and counts memory wait states with an integrated counter. It adds selectable write-through or write-back policy, with dirty-line eviction, and saturating hit/miss statistics counters. It sits between the CPU request interface and the cache datapath/memory bus, in place of the fixed-wait-state write-through controller.

Parameters:
WAIT_CYCLES, 4, memory wait states per memory access; legal range 1..2^CTR_W-1.
CTR_W, 8, wait-state counter width.
WRITE_BACK, 0, 0 = write-through/no-write-allocate; 1 = write-back/write-allocate.
STAT_W, 16, width of the hit and miss statistics counters.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
Strobe  in  1  CPU request valid; sampled in IDLE only
DRW  in  1  CPU request type: 0 = read, 1 = write
M  in  1  tag match for the addressed line
V  in  1  valid bit for the addressed line
Dirty  in  1  dirty bit for the addressed line; ignored when WRITE_BACK=0
DReady  out  1  CPU data ready / request complete, one-cycle pulse
W  out  1  cache array write enable (data, tag, valid)
DirtySet  out  1  with W: 1 = set dirty, 0 = clear dirty; always 0 when WRITE_BACK=0
MStrobe  out  1  memory request strobe, one-cycle pulse
MRW  out  1  memory direction: 0 = read, 1 = write
RSel  out  1  CPU read-data mux: 0 = cache, 1 = memory
WSel  out  1  cache write-data mux: 0 = CPU, 1 = memory
Busy  out  1  high in every state except IDLE
HitCount  out  STAT_W  saturating count of hits (read or write)
MissCount  out  STAT_W  saturating count of misses

Behaviour:
- Reset, synchronous: next state is IDLE. Wait counter, HitCount and MissCount are cleared. All 1-bit outputs are 0 in the cycle after the reset edge, including a reset mid-transaction; MStrobe drops immediately.
- Environment contract: DRW, M, V and Dirty are held stable from Strobe until DReady. Strobe while Busy is ignored, with no queueing.
- Wait counter: loads WAIT_CYCLES-1 in every MStrobe cycle and decrements in *_MEM states. CtrDone = (count == 0). Each *_MEM state lasts exactly WAIT_CYCLES cycles.
- Hit = M & V, evaluated in READ or WRITE.
- IDLE: Strobe=1 goes to READ if DRW=0, else WRITE. All outputs 0.
- READ:
  - Hit: DReady=1 (Mealy), RSel=0, then IDLE.
  - Miss with WRITE_BACK & V & Dirty: go to EVICT.
  - Other miss: go to READ_MISS.
- EVICT: MStrobe=1, MRW=1, load counter, then EVICT_MEM. EVICT_MEM waits for CtrDone, then READ_MISS.
- READ_MISS: MStrobe=1, MRW=0, load counter, then READ_MEM. READ_MEM waits for CtrDone, then READ_DATA.
- READ_DATA: W=1, WSel=1, RSel=1, DReady=1, DirtySet=0, then IDLE.
- WRITE, WRITE_BACK=0:
  - MStrobe=1, MRW=1, load counter. W=Hit (Mealy), WSel=0.
  - Then WRITE_MEM; after CtrDone, WRITE_DATA (DReady=1), then IDLE.
  - A miss does not allocate.
- WRITE, WRITE_BACK=1:
  - Hit: W=1, WSel=0, DirtySet=1, DReady=1, then IDLE. No memory access.
  - Miss with V & Dirty: EVICT path, then WRITE_ALLOC.
  - Miss otherwise: WRITE_ALLOC next.
  - WRITE_ALLOC: W=1, WSel=0, DirtySet=1, DReady=1, then IDLE.
  - EVICT_MEM returns to READ_MISS when DRW=0, WRITE_ALLOC when DRW=1.
- Statistics: the hit or miss counter increments once per request, in the READ or WRITE cycle. It saturates at all-ones with no wrap.
- Latency from the Strobe sample cycle (cycle 0), with Wc = WAIT_CYCLES:
  - Read hit: DReady in cycle 1.
  - Clean read miss: DReady in cycle 3+Wc.
  - Dirty read miss: DReady in cycle 4+2Wc.
  - Write-through write: DReady in cycle 2+Wc.
  - Write-back hit or clean miss: DReady in cycle 1 or 2.
- Unused state encodings go to IDLE.

Test Plan:
- WRITE_BACK=0, WAIT_CYCLES=4, read hit (M=V=1, DRW=0) -> DReady=1 in cycle 1, MStrobe never set, HitCount=1.
- Same config, read miss (M=0) -> MStrobe=1, MRW=0 in cycle 2; DReady=W=WSel=RSel=1 in cycle 7; MissCount=1; Busy=0 in cycle 8.
- WRITE_BACK=0, write miss -> MStrobe=1, MRW=1 and W=0 in cycle 1; DReady in cycle 6; W never asserted.
- WRITE_BACK=1, WAIT_CYCLES=2, read miss with V=1, Dirty=1 -> MStrobe/MRW=1 in cycle 2, MStrobe/MRW=0 in cycle 5, DReady with W=1 and DirtySet=0 in cycle 8.
- WRITE_BACK=1, write hit -> W=1, DirtySet=1, DReady=1 in cycle 1, no MStrobe; then a write miss with clean line -> DReady with DirtySet=1 in cycle 2.
- Assert reset in READ_MEM cycle 4 -> outputs all 0 in the next cycle, FSM in IDLE, counters 0. Strobe asserted during Busy is ignored; saturate MissCount with STAT_W=2 -> holds 3.
